fir_calc_sequencer: RTL and testbench
=====================================

Name: fir_calc_sequencer

Overview:
Sequences one shared multiply-accumulate datapath across NUM_FILTERS wavelet FIR channels, all reading the same tap vector produced by the streaming shift-register tap loader.
- Each single-cycle start_calc pulse from the loader launches one pass over all enabled filters. Each pass generates filter/tap select, MAC clear/enable and result-latch strobes.
- Flags start pulses that arrive while a pass is still running, and counts them.

Parameters:
NUM_TAPS, 9, taps per filter (>=1); one MAC cycle per tap
NUM_FILTERS, 4, number of filter channels sharing the MAC (>=1)
TAP_W, 4, width of o_tap_sel; must satisfy 2^TAP_W >= NUM_TAPS
FILT_W, 2, width of o_filter_sel; must satisfy 2^FILT_W >= NUM_FILTERS

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_start_calc  in  1  single-cycle pulse: tap vector updated, start a pass
i_filter_en  in  NUM_FILTERS  per-filter enable mask; bit k enables filter k
i_clr_overrun  in  1  clears o_overrun and o_drop_count
o_busy  out  1  high while a pass is in progress
o_filter_sel  out  FILT_W  index of the filter currently being computed
o_tap_sel  out  TAP_W  tap index presented to the MAC
o_mac_clr  out  1  clear accumulator (one cycle per filter)
o_mac_en  out  1  accumulate coeff[o_filter_sel][o_tap_sel] * tap[o_tap_sel]
o_result_latch  out  1  capture accumulator into result register of o_filter_sel
o_done  out  1  one-cycle pulse: pass complete
o_overrun  out  1  sticky: a start pulse was dropped
o_drop_count  out  8  saturating count of dropped start pulses

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset: state IDLE; all outputs 0.
  - rst mid-pass aborts the pass on the next edge.
  - No o_result_latch and no o_done are issued for an aborted pass.
- All outputs are registered. Strobes are valid in the cycle after the state transition that produces them.
- States: IDLE, CLEAR, MAC, LATCH, DONE.
- IDLE:
  - busy=0 and all strobes 0.
  - On i_start_calc=1: sample i_filter_en into en_q. The mask is held constant for the whole pass.
  - If en_q==0, go to DONE. Otherwise set filter index to the lowest set bit and go to CLEAR.
- CLEAR (1 cycle):
  - o_mac_clr=1, o_tap_sel=0, o_filter_sel=current filter.
  - Next state: MAC.
- MAC (NUM_TAPS cycles):
  - o_mac_en=1; o_tap_sel steps 0,1,...,NUM_TAPS-1, one step per cycle.
  - After tap NUM_TAPS-1, go to LATCH.
- LATCH (1 cycle):
  - o_result_latch=1, o_filter_sel unchanged.
  - If a higher-index enabled filter exists, select it and go to CLEAR. Otherwise go to DONE.
  - Disabled filters are skipped with zero cycles.
- DONE (1 cycle):
  - o_done=1, o_busy=1.
  - Next state: IDLE.
  - A new start is accepted no earlier than the cycle after DONE.
- o_busy: 1 in CLEAR, MAC, LATCH and DONE.
- o_filter_sel, o_tap_sel: hold their last values in IDLE.
- Timing:
  - Cycles per enabled filter = NUM_TAPS+2.
  - With the start sampled at edge T, o_done is high in cycle T + E*(NUM_TAPS+2) + 1, where E is the number of enabled filters.
  - Defaults with all 4 enabled: o_done at T+45.
  - Empty mask: o_done at T+1.
- Overrun:
  - i_start_calc=1 while state != IDLE (including DONE) is dropped; the current pass is unaffected.
  - A drop sets o_overrun=1 and increments o_drop_count, which saturates at 255.
  - i_clr_overrun=1 clears both on the next edge.
  - If a drop and i_clr_overrun occur in the same cycle, the result is o_overrun=1 and o_drop_count=1 (set wins over clear).
- i_filter_en changes mid-pass have no effect until the next start.

Test Plan:
- Reset, then a start pulse with mask 4'b1111 -> o_done at T+45; o_mac_clr asserted 4 times; o_mac_en asserted 36 cycles with o_tap_sel sequence 0..8 per filter; o_result_latch asserted for filters 0,1,2,3 in order.
- Mask 4'b1010 -> only filters 1 and 3 computed (11 cycles each, back-to-back); o_done at T+23.
- Mask 4'b0000 -> no clr/en/latch strobes; o_done at T+1; o_busy high for exactly 1 cycle.
- Start pulses at T+10 and at the DONE cycle of a running pass -> both dropped, pass timing unchanged, o_overrun=1, o_drop_count=2. Then i_clr_overrun coincident with a third drop -> o_overrun=1, o_drop_count=1.
- 300 drops without clear -> o_drop_count stays at 255.
- rst asserted at T+20 of a full pass -> next cycle: IDLE, all outputs 0, no o_done. A fresh start then completes normally at T'+45.

Source files
------------

// File: rtl/fir_calc_sequencer.sv
// Sequencer that time-shares one MAC across NUM_FILTERS FIR channels.
// Every accepted start runs CLEAR / MAC x NUM_TAPS / LATCH once per enabled
// filter, then a single DONE cycle. Outputs are registered from the current
// state, so each strobe appears one cycle after the state that produces it.
module fir_calc_sequencer #(
  parameter int unsigned NUM_TAPS    = 9,
  parameter int unsigned NUM_FILTERS = 4,
  parameter int unsigned TAP_W       = 4,
  parameter int unsigned FILT_W      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start_calc,
  input  logic [NUM_FILTERS-1:0] i_filter_en,
  input  logic                   i_clr_overrun,
  output logic                   o_busy,
  output logic [FILT_W-1:0]      o_filter_sel,
  output logic [TAP_W-1:0]       o_tap_sel,
  output logic                   o_mac_clr,
  output logic                   o_mac_en,
  output logic                   o_result_latch,
  output logic                   o_done,
  output logic                   o_overrun,
  output logic [7:0]             o_drop_count
);

  localparam int unsigned        CNT_W    = 8;
  localparam logic [TAP_W-1:0]   LAST_TAP = TAP_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_MAC   = 3'd2,
    S_LATCH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [NUM_FILTERS-1:0] r_en_q, w_en_q_nxt;
  logic [FILT_W-1:0]      r_filt, w_filt_nxt;
  logic [TAP_W-1:0]       r_tap, w_tap_nxt;
  logic [FILT_W-1:0]      w_first_idx, w_next_idx;
  logic                   w_next_found;
  logic                   w_drop;

  logic                   r_busy, r_mac_clr, r_mac_en, r_result_latch, r_done, r_overrun;
  logic [FILT_W-1:0]      r_filter_sel, w_filter_sel_nxt;
  logic [TAP_W-1:0]       r_tap_sel, w_tap_sel_nxt;
  logic [CNT_W-1:0]       r_drop_count;

  // Lowest enabled filter of the incoming mask, and next enabled filter above the current one.
  always_comb begin
    w_first_idx  = '0;
    w_next_idx   = '0;
    w_next_found = 1'b0;
    for (int k = NUM_FILTERS - 1; k >= 0; k--) begin
      if (i_filter_en[k]) w_first_idx = FILT_W'(k);
      if (r_en_q[k] && (k > int'(r_filt))) begin
        w_next_idx   = FILT_W'(k);
        w_next_found = 1'b1;
      end
    end
  end

  // Next-state and datapath-index logic.
  always_comb begin
    w_state_nxt = r_state;
    w_en_q_nxt  = r_en_q;
    w_filt_nxt  = r_filt;
    w_tap_nxt   = r_tap;
    case (r_state)
      S_IDLE: begin
        if (i_start_calc) begin
          w_en_q_nxt = i_filter_en;
          if (i_filter_en == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_filt_nxt  = w_first_idx;
            w_tap_nxt   = '0;
            w_state_nxt = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        w_tap_nxt   = '0;
        w_state_nxt = S_MAC;
      end
      S_MAC: begin
        if (r_tap == LAST_TAP) w_state_nxt = S_LATCH;
        else                   w_tap_nxt   = r_tap + TAP_W'(1);
      end
      S_LATCH: begin
        if (w_next_found) begin
          w_filt_nxt  = w_next_idx;
          w_tap_nxt   = '0;
          w_state_nxt = S_CLEAR;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Select outputs follow the active filter/tap and hold outside CLEAR/MAC/LATCH.
  always_comb begin
    w_filter_sel_nxt = r_filter_sel;
    w_tap_sel_nxt    = r_tap_sel;
    if (r_state == S_CLEAR || r_state == S_MAC || r_state == S_LATCH) w_filter_sel_nxt = r_filt;
    if (r_state == S_CLEAR)    w_tap_sel_nxt = '0;
    else if (r_state == S_MAC) w_tap_sel_nxt = r_tap;
  end

  assign w_drop = i_start_calc && (r_state != S_IDLE);

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_en_q         <= '0;
      r_filt         <= '0;
      r_tap          <= '0;
      r_busy         <= 1'b0;
      r_mac_clr      <= 1'b0;
      r_mac_en       <= 1'b0;
      r_result_latch <= 1'b0;
      r_done         <= 1'b0;
      r_filter_sel   <= '0;
      r_tap_sel      <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_en_q         <= w_en_q_nxt;
      r_filt         <= w_filt_nxt;
      r_tap          <= w_tap_nxt;
      r_busy         <= (r_state != S_IDLE);
      r_mac_clr      <= (r_state == S_CLEAR);
      r_mac_en       <= (r_state == S_MAC);
      r_result_latch <= (r_state == S_LATCH);
      r_done         <= (r_state == S_DONE);
      r_filter_sel   <= w_filter_sel_nxt;
      r_tap_sel      <= w_tap_sel_nxt;
    end
  end

  // Overrun flag and saturating drop counter; a drop beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun    <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
      if (i_clr_overrun)               r_drop_count <= CNT_W'(1);
      else if (r_drop_count != CNT_MAX) r_drop_count <= r_drop_count + CNT_W'(1);
    end else if (i_clr_overrun) begin
      r_overrun    <= 1'b0;
      r_drop_count <= '0;
    end
  end

  assign o_busy         = r_busy;
  assign o_filter_sel   = r_filter_sel;
  assign o_tap_sel      = r_tap_sel;
  assign o_mac_clr      = r_mac_clr;
  assign o_mac_en       = r_mac_en;
  assign o_result_latch = r_result_latch;
  assign o_done         = r_done;
  assign o_overrun      = r_overrun;
  assign o_drop_count   = r_drop_count;

endmodule

// File: tb/tb_fir_calc_sequencer.sv
// Scoreboard bench for fir_calc_sequencer: each accepted start pushes the
// complete expected strobe schedule (absolute cycle, kind, filter, tap);
// a monitor pops and compares whenever the DUT shows a strobe.
module tb_fir_calc_sequencer;

  localparam int NT = 9;
  localparam int NF = 4;
  localparam int PER = NT + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start_calc;
  logic [3:0] i_filter_en;
  logic       i_clr_overrun;
  logic       o_busy;
  logic [1:0] o_filter_sel;
  logic [3:0] o_tap_sel;
  logic       o_mac_clr, o_mac_en, o_result_latch, o_done, o_overrun;
  logic [7:0] o_drop_count;

  fir_calc_sequencer #(.NUM_TAPS(NT), .NUM_FILTERS(NF), .TAP_W(4), .FILT_W(2)) dut (
    .clk(clk), .rst(rst), .i_start_calc(i_start_calc), .i_filter_en(i_filter_en),
    .i_clr_overrun(i_clr_overrun), .o_busy(o_busy), .o_filter_sel(o_filter_sel),
    .o_tap_sel(o_tap_sel), .o_mac_clr(o_mac_clr), .o_mac_en(o_mac_en),
    .o_result_latch(o_result_latch), .o_done(o_done), .o_overrun(o_overrun),
    .o_drop_count(o_drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic clr, en, lat, done;
    int   filt;
    int   tap;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_fail = 0;
  int  p_start = -10;
  int  p_end = -1;
  logic m_ovr = 1'b0;
  int  m_cnt = 0;

  always @(posedge clk) cyc++;

  function automatic ev_t mk(int c, logic a, logic b, logic l, logic d, int f, int t);
    ev_t e;
    e.cyc = c; e.clr = a; e.en = b; e.lat = l; e.done = d; e.filt = f; e.tap = t;
    return e;
  endfunction

  // One stimulus cycle: drive at negedge, update the reference model for the coming edge.
  task automatic step(input logic st, input logic [3:0] m, input logic c, input logic r);
    int   s;
    int   j;
    logic dr;
    rst = r; i_start_calc = st; i_filter_en = m; i_clr_overrun = c;
    s = cyc + 1;
    if (r) begin
      q.delete();
      m_ovr = 1'b0; m_cnt = 0; p_start = -10; p_end = -1;
    end else begin
      dr = st && (s <= p_end);
      if (st && !dr) begin
        j = 0;
        for (int k = 0; k < NF; k++) begin
          if (m[k]) begin
            q.push_back(mk(s + 1 + j*PER, 1'b1, 1'b0, 1'b0, 1'b0, k, 0));
            for (int t = 0; t < NT; t++)
              q.push_back(mk(s + 2 + j*PER + t, 1'b0, 1'b1, 1'b0, 1'b0, k, t));
            q.push_back(mk(s + PER + j*PER, 1'b0, 1'b0, 1'b1, 1'b0, k, 0));
            j++;
          end
        end
        q.push_back(mk(s + j*PER + 1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0));
        p_start = s;
        p_end = s + j*PER + 1;
      end
      if (dr) begin
        m_ovr = 1'b1;
        m_cnt = c ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
      end else if (c) begin
        m_ovr = 1'b0; m_cnt = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
  endtask

  // Monitor: strobe scoreboard plus per-cycle busy / overrun / drop-count checks.
  always begin
    ev_t  e;
    logic got, exp_any, bad;
    logic exp_busy;
    @(posedge clk);
    #1;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_cmp++; n_fail++;
      $display("FAIL missed_strobe expected_at=%0d now=%0d", q[0].cyc, cyc);
      void'(q.pop_front());
    end
    got = o_mac_clr | o_mac_en | o_result_latch | o_done;
    exp_any = (q.size() > 0) && (q[0].cyc == cyc);
    e = exp_any ? q[0] : mk(cyc, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    if (got || exp_any) begin
      n_cmp++;
      bad = ({o_mac_clr, o_mac_en, o_result_latch, o_done} != {e.clr, e.en, e.lat, e.done});
      if ((e.clr || e.en || e.lat) && (int'(o_filter_sel) != e.filt)) bad = 1'b1;
      if ((e.clr || e.en) && (int'(o_tap_sel) != e.tap)) bad = 1'b1;
      if (bad)
        $display("FAIL strobe cyc=%0d got clr/en/lat/done=%b%b%b%b f=%0d t=%0d need %b%b%b%b f=%0d t=%0d",
                 cyc, o_mac_clr, o_mac_en, o_result_latch, o_done, o_filter_sel, o_tap_sel,
                 e.clr, e.en, e.lat, e.done, e.filt, e.tap);
      if (bad) n_fail++;
      if (exp_any) void'(q.pop_front());
    end
    exp_busy = (cyc >= p_start + 1) && (cyc <= p_end);
    n_cmp++;
    if (o_busy !== exp_busy || o_overrun !== m_ovr || int'(o_drop_count) != m_cnt) begin
      n_fail++;
      $display("FAIL status cyc=%0d got busy=%b ovr=%b cnt=%0d need busy=%b ovr=%b cnt=%0d",
               cyc, o_busy, o_overrun, o_drop_count, exp_busy, m_ovr, m_cnt);
    end
  end

  initial begin
    int t0;
    rst = 1'b1; i_start_calc = 1'b0; i_filter_en = 4'h0; i_clr_overrun = 1'b0;
    @(negedge clk);
    step(1'b0, 4'hF, 1'b0, 1'b1);
    step(1'b0, 4'hF, 1'b0, 1'b1);
    // Reset state of the select outputs.
    n_cmp++;
    if (o_filter_sel !== 2'd0 || o_tap_sel !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_sel got f=%0d t=%0d need 0 0", o_filter_sel, o_tap_sel);
    end
    idle(2);

    // Full mask, sparse mask, empty mask.
    step(1'b1, 4'b1111, 1'b0, 1'b0); idle(50);
    step(1'b1, 4'b1010, 1'b0, 1'b0); idle(30);
    step(1'b1, 4'b0000, 1'b0, 1'b0); idle(5);

    // Drops at T+10 and at the DONE-state edge T+45, then clear coincident with a drop.
    t0 = cyc + 1;
    step(1'b1, 4'b1111, 1'b0, 1'b0);
    while (cyc + 1 < t0 + 10) idle(1);
    step(1'b1, 4'h0, 1'b0, 1'b0);
    while (cyc + 1 < t0 + 45) idle(1);
    step(1'b1, 4'h0, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 4'b0110, 1'b0, 1'b0); idle(4);
    step(1'b1, 4'b0001, 1'b1, 1'b0); idle(30);
    step(1'b0, 4'h0, 1'b1, 1'b0); idle(2);

    // Continuous start requests: back-to-back passes and counter saturation.
    for (int i = 0; i < 340; i++) step(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
    idle(50);
    step(1'b0, 4'h0, 1'b1, 1'b0); idle(2);

    // Reset at T+20 of a full pass, then a fresh full pass.
    t0 = cyc + 1;
    step(1'b1, 4'b1111, 1'b0, 1'b0);
    while (cyc + 1 < t0 + 20) idle(1);
    step(1'b0, 4'hF, 1'b0, 1'b1);
    idle(2);
    step(1'b1, 4'b1111, 1'b0, 1'b0); idle(50);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 29) == 0), 1'b0);
    idle(60);

    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending strobes need 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
